// File: rtl/qar_dac.sv
// rtl/qar_dac.sv - bus-mapped 4-channel DAC controller with manual settle path and streamed FIFO drain
module qar_dac #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 12,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_write,
    input  logic             bus_read,
    input  logic [4:0]       addr_word,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] dac0,
    output logic [WIDTH-1:0] dac1,
    output logic [WIDTH-1:0] dac2,
    output logic [WIDTH-1:0] dac3,
    output logic             update,
    output logic             irq
);
    localparam logic [4:0] A_CTRL   = 5'h0;
    localparam logic [4:0] A_STATUS = 5'h1;
    localparam logic [4:0] A_DATA   = 5'h2;
    localparam logic [4:0] A_IRQEN  = 5'h3;
    localparam logic [4:0] A_IRQST  = 5'h4;
    localparam logic [4:0] A_THRESH = 5'h5;
    localparam logic [4:0] A_DIV    = 5'h6;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(SETTLE_LATENCY) + 1;

    logic             enable;
    logic             stream;
    logic [1:0]       stream_ch;
    logic [2:0]       irq_en;
    logic [2:0]       irq_status;
    logic             underrun_flag;
    logic [3:0]       fifo_thresh;
    logic [15:0]      update_div;

    logic             busy;
    logic [SW-1:0]    settle_cnt;
    logic [WIDTH-1:0] pend_code;
    logic [1:0]       pend_ch;

    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [3:0]       fifo_level;
    logic [15:0]      div_cnt;
    logic [WIDTH-1:0] dac_q [CHANNELS];

    logic wr_ctrl, wr_data, wr_irqst;
    logic manual_mode, stream_mode, mode_flush;
    logic data_acc, data_drop, settle_done;
    logic fifo_empty, fifo_full;
    logic tick_raw, tick, pop, push_req, push, overflow;
    logic underrun_set, fifo_low_set;
    logic [15:0] eff_div;
    logic [2:0]  irq_set, irq_w1c;
    logic unused_wdata;

    assign unused_wdata = &{1'b0, wdata[31:22], wdata[19:16]};

    assign wr_ctrl  = bus_write && (addr_word == A_CTRL);
    assign wr_data  = bus_write && (addr_word == A_DATA);
    assign wr_irqst = bus_write && (addr_word == A_IRQST);

    assign manual_mode = enable && !stream;
    assign stream_mode = enable && stream;
    assign mode_flush  = wr_ctrl && (!wdata[0] || (wdata[1] != stream));

    assign data_acc    = wr_data && manual_mode && !busy;
    assign data_drop   = wr_data && manual_mode && busy;
    assign settle_done = busy && (settle_cnt == SW'(SETTLE_LATENCY - 1));

    assign fifo_empty = (fifo_level == 4'd0);
    assign fifo_full  = (fifo_level == 4'(FIFO_DEPTH));
    assign eff_div    = (update_div == 16'd0) ? 16'd1 : update_div;

    // A CTRL write in the same cycle as a tick swallows the tick.
    assign tick_raw = stream_mode && (div_cnt >= eff_div);
    assign tick     = tick_raw && !wr_ctrl;
    assign pop      = tick && !fifo_empty;
    assign push_req = wr_data && stream_mode;
    assign push     = push_req && (!fifo_full || pop);
    assign overflow = push_req && fifo_full && !pop;

    assign underrun_set = tick && fifo_empty;
    assign fifo_low_set = stream_mode && (fifo_level <= fifo_thresh);

    assign irq_set = {overflow || data_drop, underrun_set, fifo_low_set};
    assign irq_w1c = wr_irqst ? wdata[2:0] : 3'b000;

    assign dac0 = dac_q[0];
    assign dac1 = dac_q[1];
    assign dac2 = dac_q[2];
    assign dac3 = dac_q[3];
    assign irq  = |(irq_en & irq_status);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable        <= 1'b0;
            stream        <= 1'b0;
            stream_ch     <= 2'd0;
            irq_en        <= 3'd0;
            irq_status    <= 3'd0;
            underrun_flag <= 1'b0;
            fifo_thresh   <= 4'd1;
            update_div    <= 16'd16;
        end else begin
            if (wr_ctrl) begin
                enable    <= wdata[0];
                stream    <= wdata[1];
                stream_ch <= wdata[5:4];
            end
            if (bus_write && addr_word == A_IRQEN)  irq_en      <= wdata[2:0];
            if (bus_write && addr_word == A_THRESH) fifo_thresh <= wdata[3:0];
            if (bus_write && addr_word == A_DIV)    update_div  <= wdata[15:0];
            // Hardware set beats a simultaneous W1C.
            irq_status <= (irq_status & ~irq_w1c) | irq_set;
            if (underrun_set)
                underrun_flag <= 1'b1;
            else if (wr_irqst && wdata[1])
                underrun_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            settle_cnt <= '0;
            pend_code  <= '0;
            pend_ch    <= 2'd0;
            update     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) dac_q[i] <= '0;
        end else begin
            update <= 1'b0;
            if (mode_flush) begin
                busy       <= 1'b0;
                settle_cnt <= '0;
            end else if (data_acc) begin
                busy       <= 1'b1;
                settle_cnt <= '0;
                pend_code  <= wdata[WIDTH-1:0];
                pend_ch    <= wdata[21:20];
            end else if (settle_done) begin
                busy           <= 1'b0;
                dac_q[pend_ch] <= pend_code;
                update         <= 1'b1;
            end else if (busy) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (pop) begin
                dac_q[stream_ch] <= fifo_mem[rd_ptr];
                update           <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= 4'd0;
            div_cnt    <= 16'd0;
        end else begin
            if (mode_flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= 4'd0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                fifo_level <= fifo_level + {3'b000, push} - {3'b000, pop};
            end
            if (mode_flush || !stream_mode || tick_raw)
                div_cnt <= 16'd0;
            else
                div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !mode_flush) fifo_mem[wr_ptr] <= wdata[WIDTH-1:0];
    end

    always_comb begin
        rdata = 32'd0;
        if (bus_read) begin
            case (addr_word)
                A_CTRL:   rdata = {26'd0, stream_ch, 2'b00, stream, enable};
                A_STATUS: rdata = {24'd0, fifo_level, underrun_flag, fifo_full, fifo_empty, busy};
                A_IRQEN:  rdata = {29'd0, irq_en};
                A_IRQST:  rdata = {29'd0, irq_status};
                A_THRESH: rdata = {28'd0, fifo_thresh};
                A_DIV:    rdata = {16'd0, update_div};
                default:  rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: doc/qar_dac.md
Name: qar_dac

Overview:
- Bus-mapped 4-channel DAC output controller, the transmit-side counterpart of the ADC peripheral; sits on the same peripheral word-address bus.
- Manual mode: a CPU write sets one channel output after a fixed settle latency.
- Stream mode: samples are written into a small FIFO and drained to one selected channel at a programmable update rate.
- Raises an interrupt on FIFO-low, underrun and overflow.

Parameters:
CHANNELS, 4, number of analog output channels; fixed at 4, 2-bit channel index.
WIDTH, 12, DAC code width in bits.
FIFO_DEPTH, 4, stream FIFO entries; power of two, at most 8.
SETTLE_LATENCY, 4, cycles from manual-write acceptance to output change; at least 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
bus_write  in  1  single-cycle register write strobe
bus_read  in  1  register read strobe
addr_word  in  5  register word address
wdata  in  32  write data
rdata  out  32  combinational read data; 0 when bus_read is low
dac0, dac1, dac2, dac3  out  WIDTH each  registered channel output codes
update  out  1  one-cycle pulse in the cycle any dacN changes
irq  out  1  OR of (irq_en AND irq_status)

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-high.
  - Reset state: dac0..3=0, update=0, irq=0, FIFO empty, all registers at reset values.
  - Reset mid-operation aborts any settle or stream in progress.
- Register map:
  - 0x0 CTRL, RW, reset 0: [0] enable, [1] stream, [5:4] stream_ch.
  - 0x1 STATUS, RO: [0] busy, [1] fifo_empty, [2] fifo_full, [3] underrun_flag, [7:4] fifo_level.
  - 0x2 DATA, WO, reads 0: [WIDTH-1:0] code, [21:20] channel (manual mode only).
  - 0x3 IRQ_EN, RW, reset 0.
  - 0x4 IRQ_STATUS, W1C: [0] fifo_low, [1] underrun, [2] overflow. Writing bit1 also clears underrun_flag.
  - 0x5 FIFO_THRESH, RW, reset 1, low 4 bits.
  - 0x6 UPDATE_DIV, RW, reset 16, 16 bits; value 0 is treated as 1.
- Manual mode (enable=1, stream=0):
  - A DATA write with busy=0 latches code and channel, sets busy, and clears the settle counter.
  - After SETTLE_LATENCY cycles the selected dacN takes the code, update pulses, and busy clears in the same cycle.
  - A DATA write while busy=1 is dropped and sets IRQ_STATUS[2].
  - A DATA write while enable=0 is ignored, with no flag.
- Stream mode (enable=1, stream=1):
  - A DATA write pushes code[WIDTH-1:0] into the FIFO; channel bits are ignored.
  - Push while full with no pop in the same cycle: dropped, sets IRQ_STATUS[2].
  - Simultaneous push and pop while full: both succeed, level unchanged.
  - The update counter increments each cycle. When counter >= effective_div, the counter resets to 0 and a tick occurs; update period = effective_div+1 cycles.
  - On a tick with FIFO non-empty: pop the head and drive dac[stream_ch] with it on the next edge; update pulses that cycle.
  - On a tick with FIFO empty: outputs hold, underrun_flag=1, IRQ_STATUS[1]=1.
  - fifo_low: IRQ_STATUS[0] is set every cycle that fifo_level <= FIFO_THRESH. It is level-driven, so clearing it by W1C while the condition still holds has no effect.
- Mode changes:
  - Writing CTRL with enable=0, or changing the stream bit, flushes the FIFO, zeroes the counter, and cancels any pending settle (busy=0).
  - dacN outputs always hold their last values.
- Simultaneous events:
  - A hardware set and a W1C of the same IRQ_STATUS bit in one cycle: set wins.
  - A CTRL write and a tick in the same cycle: the CTRL write takes effect and the tick is discarded.
- Widths:
  - fifo_level counts 0..FIFO_DEPTH in 4 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Manual write: CTRL=0x1, DATA=0x00200ABC → after 4 cycles dac2=0xABC, update pulse for 1 cycle, busy high for exactly 4 cycles, other channels remain 0.
- Busy collision: second DATA write 2 cycles after the first → dropped, IRQ_STATUS=0x4, dac holds the first code; with IRQ_EN=0x4, irq=1 until 0x4 is written to IRQ_STATUS.
- Streaming: CTRL=0x13, UPDATE_DIV=3, push 0x111, 0x222, 0x333 → dac1 steps through them at 4-cycle intervals; the 4th tick sets underrun with no further output change.
- Overflow/full: stream mode, 5 pushes with no ticks (UPDATE_DIV=0xFFFF) → STATUS fifo_full=1, level=4, IRQ_STATUS[2]=1, FIFO holds the first 4 codes.
- Threshold/flush: FIFO_THRESH=2, level 3 → fifo_low=0; after a pop it becomes 1. Writing CTRL=0x0 → level=0, dac values held.
- Reset mid-stream: assert rst during streaming → all dacN=0, rdata STATUS=0x2 (empty) after release, irq=0.
